// File: rtl/commit_trace_pkg.sv
// Shared types and width constants for the commit trace controller.
// The per-entry skip bit exists only when DIFFTEST_SKIP_EN is defined.
package commit_trace_pkg;

    localparam int CT_PC_WD      = 64;
    localparam int CT_INST_WD    = 32;
    localparam int CT_RF_ADDR_WD = 5;
    localparam int CT_RF_DATA_WD = 64;
    localparam int CT_CNT_WD     = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CT_PC_WD-1:0]      pc;
        logic [CT_PC_WD-1:0]      dnpc;
        logic [CT_INST_WD-1:0]    inst;
        logic                     stop;
        logic                     rf_wen;
        logic [CT_RF_ADDR_WD-1:0] rf_wnum;
        logic [CT_RF_DATA_WD-1:0] rf_wdata;
`ifdef DIFFTEST_SKIP_EN
        logic                     skip;
`endif
    } commit_entry_t;

    localparam int ENTRY_WD = $bits(commit_entry_t);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CT_CNT_WD-1:0] sat_inc(input logic [CT_CNT_WD-1:0] value);
        return (value == {CT_CNT_WD{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of packed commit records with registered storage;
// pointers carry one extra wrap bit to tell full from empty.
module commit_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_push,
    input  logic [ENTRY_WD-1:0] i_wdata,
    input  logic                i_pop,
    output logic [ENTRY_WD-1:0] o_rdata,
    output logic                o_full,
    output logic                o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [ENTRY_WD-1:0] r_mem [DEPTH];
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values of the others.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/commit_trace_ctrl.sv
// Buffers writeback commits for the trace consumer and runs the stop/drain/halt
// sequence. Optional macro DIFFTEST_SKIP_EN adds the ws_skip/cm_skip ports.
module commit_trace_ctrl
    import commit_trace_pkg::*;
#(
    parameter int PC_WD      = CT_PC_WD,
    parameter int INST_WD    = CT_INST_WD,
    parameter int RF_ADDR_WD = CT_RF_ADDR_WD,
    parameter int RF_DATA_WD = CT_RF_DATA_WD,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ws_valid,
    output logic                  ws_ready,
    input  logic [PC_WD-1:0]      ws_pc,
    input  logic [PC_WD-1:0]      ws_dnpc,
    input  logic [INST_WD-1:0]    ws_inst,
    input  logic                  ws_stop,
    input  logic                  ws_rf_wen,
    input  logic [RF_ADDR_WD-1:0] ws_rf_wnum,
    input  logic [RF_DATA_WD-1:0] ws_rf_wdata,
    output logic                  cm_valid,
    input  logic                  cm_ready,
    output logic [PC_WD-1:0]      cm_pc,
    output logic [PC_WD-1:0]      cm_dnpc,
    output logic [INST_WD-1:0]    cm_inst,
    output logic                  cm_stop,
    output logic                  cm_rf_wen,
    output logic [RF_ADDR_WD-1:0] cm_rf_wnum,
    output logic [RF_DATA_WD-1:0] cm_rf_wdata,
    output logic                  halt,
    output logic [63:0]           retired
`ifdef DIFFTEST_SKIP_EN
    ,
    input  logic                  ws_skip,
    output logic                  cm_skip
`endif
);

    state_e              r_state;
    state_e              w_next_state;
    logic [63:0]         r_retired;
    commit_entry_t       w_wr_entry;
    commit_entry_t       w_rd_entry;
    logic [ENTRY_WD-1:0] w_rd_bits;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_ws_ready;
    logic                w_cm_valid;
    logic                w_halt;

    assign w_push     = ws_valid && w_ws_ready;
    assign w_pop      = w_cm_valid && cm_ready;
    assign w_rd_entry = commit_entry_t'(w_rd_bits);

    always_comb begin
        w_wr_entry          = '0;
        w_wr_entry.pc       = ws_pc;
        w_wr_entry.dnpc     = ws_dnpc;
        w_wr_entry.inst     = ws_inst;
        w_wr_entry.stop     = ws_stop;
        w_wr_entry.rf_wen   = ws_rf_wen;
        w_wr_entry.rf_wnum  = ws_rf_wnum;
        w_wr_entry.rf_wdata = ws_rf_wdata;
`ifdef DIFFTEST_SKIP_EN
        w_wr_entry.skip     = ws_skip;
`endif
    end

    commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_rd_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        w_next_state = r_state;
        case (r_state)
            RUN:     if (w_push && ws_stop)         w_next_state = DRAIN;
            DRAIN:   if (w_pop && w_rd_entry.stop)  w_next_state = HALT;
            HALT:                                   w_next_state = HALT;
            default:                                w_next_state = RUN;
        endcase
    end

    always_comb begin
        w_ws_ready = 1'b0;
        w_cm_valid = 1'b0;
        w_halt     = 1'b0;
        case (r_state)
            RUN: begin
                w_ws_ready = !w_full;
                w_cm_valid = !w_empty;
            end
            DRAIN:   w_cm_valid = !w_empty;
            HALT:    w_halt     = 1'b1;
            default: w_ws_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_retired <= '0;
        else if (w_pop) r_retired <= sat_inc(r_retired);
    end

    // Fields read as zero when no record is offered, so unwritten storage never leaks out.
    assign ws_ready    = w_ws_ready;
    assign cm_valid    = w_cm_valid;
    assign halt        = w_halt;
    assign retired     = r_retired;
    assign cm_pc       = w_cm_valid ? w_rd_entry.pc       : '0;
    assign cm_dnpc     = w_cm_valid ? w_rd_entry.dnpc     : '0;
    assign cm_inst     = w_cm_valid ? w_rd_entry.inst     : '0;
    assign cm_stop     = w_cm_valid ? w_rd_entry.stop     : 1'b0;
    assign cm_rf_wen   = w_cm_valid ? w_rd_entry.rf_wen   : 1'b0;
    assign cm_rf_wnum  = w_cm_valid ? w_rd_entry.rf_wnum  : '0;
    assign cm_rf_wdata = w_cm_valid ? w_rd_entry.rf_wdata : '0;
`ifdef DIFFTEST_SKIP_EN
    assign cm_skip     = w_cm_valid ? w_rd_entry.skip     : 1'b0;
`endif

endmodule

// File: doc/commit_trace_ctrl.md
Name: commit_trace_ctrl

Overview:
Sequences retired-instruction records from the writeback stage to the simulation difftest/trace consumer.
- Buffers each writeback commit (pc, dnpc, inst, rf write) in a small FIFO.
- Back-pressures writeback when the FIFO is full.
- Drains records one per accepted handshake.
- Runs the halt sequence: stop → drain all older commits → sticky halt.
- Sits between wb_stage and the DPI-C export shim, replacing its ad-hoc delay pipes.

Parameters:
PC_WD, 64, pc/dnpc width
INST_WD, 32, instruction width
RF_ADDR_WD, 5, register-number width
RF_DATA_WD, 64, register write-data width
DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ws_valid  in  1  writeback stage holds a retiring instruction
ws_ready  out  1  controller can accept this cycle's commit
ws_pc  in  PC_WD  pc of retiring instruction
ws_dnpc  in  PC_WD  next pc after it
ws_inst  in  INST_WD  instruction word
ws_stop  in  1  retiring instruction is the halt (ebreak) instruction
ws_rf_wen  in  1  register write enable
ws_rf_wnum  in  RF_ADDR_WD  destination register
ws_rf_wdata  in  RF_DATA_WD  write data
ws_skip  in  1  difftest skip flag (only with DIFFTEST_SKIP_EN)
cm_valid  out  1  record available
cm_ready  in  1  consumer takes record
cm_pc, cm_dnpc, cm_inst, cm_rf_wen, cm_rf_wnum, cm_rf_wdata  out  as ws_*  record fields
cm_stop  out  1  record is the halt instruction
cm_skip  out  1  difftest skip (only with DIFFTEST_SKIP_EN)
halt  out  1  sticky; all commits up to and including stop have drained
retired  out  64  count of records popped

Behaviour:
Reset values:
- Asynchronous reset; all outputs 0 except ws_ready=1.
- State RUN, FIFO empty, retired=0.
- Reset mid-drain or mid-halt discards all entries and returns to RUN.

Push: ws_valid && ws_ready at a rising edge writes one entry at the write pointer.

Pop: cm_valid && cm_ready advances the read pointer and increments retired.

Latency and output stability:
- Registered FIFO: an entry pushed at edge N is visible on cm_* from N+1.
- No combinational ws→cm path.
- cm_* stay stable while cm_valid && !cm_ready.

Pointers and occupancy:
- Read/write pointers are $clog2(DEPTH)+1 bits; wrap naturally.
- full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Simultaneous push+pop in a non-full, non-empty state leaves occupancy unchanged.
- When full, ws_ready=0, even if a pop occurs the same cycle (no bypass, no same-cycle refill).
- Push while empty and pop that same cycle: pop is not possible, since cm_valid=0.

FSM:
- RUN: ws_ready = !full. Accepting an entry with ws_stop=1 → DRAIN.
- DRAIN: ws_ready=0. When the popped entry has cm_stop=1 → HALT. That entry is by construction the last, so the FIFO is empty.
- HALT: halt=1, ws_ready=0, cm_valid=0. Exit only by reset.

Other rules:
- ws_stop with ws_valid=0 is ignored.
- retired saturates at 2^64-1.
- Entry fields are stored unmodified; ws_rf_wnum is held at full width.

Optional Feature:
Macro DIFFTEST_SKIP_EN.
- Defined: ws_skip and cm_skip ports exist; the skip bit is stored per entry and presented with the record. The consumer treats the record as "copy DUT state, do not compare".
- Undefined: both ports are absent, the entry is one bit narrower, and behaviour is otherwise identical.

Decomposition:
Shared package commit_trace_pkg holds:
- width constants;
- the state enum {RUN, DRAIN, HALT};
- the commit_entry_t packed struct {pc, dnpc, inst, stop, rf_wen, rf_wnum, rf_wdata, skip under the macro}.

One sub-module, commit_fifo: parameterised synchronous FIFO of commit_entry_t, with full/empty and push/pop. The FSM, ws_ready/halt generation and the retired counter stay in the top.

Test Plan:
- Reset then 3 back-to-back commits (pc 0x80000000/4/8, cm_ready=1) → cm_valid rises 1 cycle after the first push; pcs emerge in order on consecutive cycles; retired=3.
- cm_ready=0, push 5 commits with DEPTH=4 → ws_ready=0 after the 4th push and the 5th is held; raising cm_ready pops 0x80000000 first; the 5th is accepted 1 cycle after the first pop.
- Full FIFO, simultaneous pop and ws_valid → pop occurs, push refused that cycle, ws_ready=1 next cycle.
- Commits A, B, then C with ws_stop=1, consumer stalled 2 cycles → ws_ready=0 after C; halt=1 in the cycle after C pops; retired=3; further ws_valid is ignored.
- Assert reset in DRAIN with 2 entries queued → cm_valid=0, halt=0, ws_ready=1 immediately (asynchronous); a new commit after reset emerges normally.
- DIFFTEST_SKIP_EN defined, commit with ws_skip=1 followed by ws_skip=0 → cm_skip=1 then 0, aligned with the respective pcs.
